// File: rtl/id_ex_stage.sv
// ID/EX one-entry pipeline register with operand resolution and immediate extension.
// Optional writeback bypass and stall refresh enabled by ID_EX_BYPASS_EN.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic              in_zext,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic [4:0]        rf_rs,
   output logic [4:0]        rf_rt,
   input  logic [DATA_W-1:0] rf_data0,
   input  logic [DATA_W-1:0] rf_data1,
   input  logic              wb_write,
   input  logic [4:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [DATA_W-1:0] out_imm,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_rd,
   output logic [CTRL_W-1:0] out_ctrl
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e state_q, state_d;

   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [4:0]        rs_q, rs_d;
   logic [4:0]        rt_q, rt_d;
   logic [4:0]        rd_q, rd_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   logic              capture;
   logic              drain;
   logic              byp_a, byp_b;
   logic              upd_a, upd_b;
   logic [DATA_W-1:0] op_a, op_b;
   logic [DATA_W-1:0] imm_ext;

   assign rf_rs    = in_rs;
   assign rf_rt    = in_rt;
   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready && !flush;
   assign drain    = out_valid && out_ready;

`ifdef ID_EX_BYPASS_EN
   logic wb_hit;
   assign wb_hit = wb_write && (wb_rd != 5'd0);
   assign byp_a  = wb_hit && (wb_rd == in_rs);
   assign byp_b  = wb_hit && (wb_rd == in_rt);
   // Refresh a stalled operand so it never goes stale behind a writeback
   assign upd_a  = out_valid && !out_ready && !flush
                   && wb_hit && (wb_rd == rs_q);
   assign upd_b  = out_valid && !out_ready && !flush
                   && wb_hit && (wb_rd == rt_q);
`else
   logic unused_wb;
   assign unused_wb = ^{wb_write, wb_rd, wb_data};
   assign byp_a     = 1'b0;
   assign byp_b     = 1'b0;
   assign upd_a     = 1'b0;
   assign upd_b     = 1'b0;
`endif

   always_comb begin
      op_a = rf_data0;
      if (in_rs == 5'd0) op_a = '0;
      else if (byp_a)    op_a = wb_data;
      op_b = rf_data1;
      if (in_rt == 5'd0) op_b = '0;
      else if (byp_b)    op_b = wb_data;
   end

   assign imm_ext = {{(DATA_W-16){in_imm[15] & ~in_zext}}, in_imm};

   always_ff @(posedge clk) begin
      if (!reset) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // flush dominates, then capture, then drain
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (!flush && capture) state_d = FULL;
         FULL: begin
            if (flush)         state_d = EMPTY;
            else if (capture)  state_d = FULL;
            else if (drain)    state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state_q == FULL);
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      imm_d  = imm_q;
      rs_d   = rs_q;
      rt_d   = rt_q;
      rd_d   = rd_q;
      ctrl_d = ctrl_q;
      if (capture) begin
         a_d    = op_a;
         b_d    = op_b;
         imm_d  = imm_ext;
         rs_d   = in_rs;
         rt_d   = in_rt;
         rd_d   = in_rd;
         ctrl_d = in_ctrl;
      end else begin
         if (upd_a) a_d = wb_data;
         if (upd_b) b_d = wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_q    <= '0;
         b_q    <= '0;
         imm_q  <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         rd_q   <= '0;
         ctrl_q <= '0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         imm_q  <= imm_d;
         rs_q   <= rs_d;
         rt_q   <= rt_d;
         rd_q   <= rd_d;
         ctrl_q <= ctrl_d;
      end
   end

   assign out_a    = a_q;
   assign out_b    = b_q;
   assign out_imm  = imm_q;
   assign out_rs   = rs_q;
   assign out_rt   = rt_q;
   assign out_rd   = rd_q;
   assign out_ctrl = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus random traffic
// against a transaction-level model of the held instruction.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_rs, in_rt, in_rd;
   logic [15:0]   in_imm;
   logic          in_zext;
   logic [CW-1:0] in_ctrl;
   logic [4:0]    rf_rs, rf_rt;
   logic [DW-1:0] rf_data0, rf_data1;
   logic          wb_write;
   logic [4:0]    wb_rd;
   logic [DW-1:0] wb_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_a, out_b, out_imm;
   logic [4:0]    out_rs, out_rt, out_rd;
   logic [CW-1:0] out_ctrl;

   id_ex_stage #(.DATA_W(DW), .CTRL_W(CW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .in_zext(in_zext), .in_ctrl(in_ctrl),
      .rf_rs(rf_rs), .rf_rt(rf_rt),
      .rf_data0(rf_data0), .rf_data1(rf_data1),
      .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
      .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_ctrl(out_ctrl)
   );

   always #5 clk = ~clk;

`ifdef ID_EX_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // model of the held instruction
   bit            m_v = 1'b0;
   logic [DW-1:0] m_a, m_b, m_imm;
   logic [4:0]    m_rs, m_rt, m_rd;
   logic [CW-1:0] m_ctrl;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] resolve(input logic [4:0] idx,
                                             input logic [DW-1:0] rf);
      if (idx == 0) return '0;
      if (BYP && wb_write && wb_rd != 0 && wb_rd == idx) return wb_data;
      return rf;
   endfunction

   task automatic cmp_all();
      chk("out_valid", out_valid, m_v);
      if (m_v) begin
         chk("out_a", out_a, m_a);
         chk("out_b", out_b, m_b);
         chk("out_imm", out_imm, m_imm);
         chk("out_rs", out_rs, m_rs);
         chk("out_rt", out_rt, m_rt);
         chk("out_rd", out_rd, m_rd);
         chk("out_ctrl", out_ctrl, m_ctrl);
      end
   endtask

   // inputs are already applied; check combinational outputs, clock, update model
   task automatic step();
      bit cap;
      #1;
      chk("in_ready", in_ready, !m_v || out_ready);
      chk("rf_rs", rf_rs, in_rs);
      chk("rf_rt", rf_rt, in_rt);
      cap = in_valid && (!m_v || out_ready) && !flush;
      @(posedge clk);
      if (!reset) begin
         m_v = 0; m_a = '0; m_b = '0; m_imm = '0;
         m_rs = '0; m_rt = '0; m_rd = '0; m_ctrl = '0;
      end else if (flush) begin
         m_v = 0;
      end else if (cap) begin
         m_v    = 1;
         m_a    = resolve(in_rs, rf_data0);
         m_b    = resolve(in_rt, rf_data1);
         m_imm  = in_zext ? DW'(in_imm) : DW'(signed'(in_imm));
         m_rs   = in_rs;
         m_rt   = in_rt;
         m_rd   = in_rd;
         m_ctrl = in_ctrl;
      end else if (m_v && out_ready) begin
         m_v = 0;
      end else if (m_v && BYP && wb_write && wb_rd != 0) begin
         if (wb_rd == m_rs) m_a = wb_data;
         if (wb_rd == m_rt) m_b = wb_data;
      end
      @(negedge clk);
      cmp_all();
   endtask

   task automatic idle();
      in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0;
      in_imm = 0; in_zext = 0; in_ctrl = 0;
      rf_data0 = 0; rf_data1 = 0;
      wb_write = 0; wb_rd = 0; wb_data = 0;
      flush = 0; out_ready = 1;
   endtask

   logic [DW-1:0] hold_b;

   initial begin
      idle();
      reset    = 0;
      in_valid = 1;
      in_rs    = 5'd4;
      in_imm   = 16'h1234;
      rf_data0 = 32'hDEAD;
      @(posedge clk);
      @(negedge clk);
      step();
      step();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_a", out_a, 0);
      chk("rst_b", out_b, 0);
      chk("rst_imm", out_imm, 0);
      chk("rst_idx", {out_rs, out_rt, out_rd}, 0);
      chk("rst_ctrl", out_ctrl, 0);
      chk("rst_ready", in_ready, 1'b1);

      reset = 1;
      idle();
      in_valid = 1; in_rs = 5'd3; rf_data0 = 32'h11;
      in_rt = 5'd0; rf_data1 = 32'h55;
      in_imm = 16'h8001; in_zext = 0; in_ctrl = 8'hA5;
      step();
      chk("cap_a", out_a, 32'h11);
      chk("cap_b", out_b, 32'h0);
      chk("cap_imm", out_imm, 32'hFFFF8001);

      in_zext = 1;
      step();
      chk("zext_imm", out_imm, 32'h0000_8001);

      idle();
      in_valid = 1; in_rs = 5'd5; rf_data0 = 32'hAAAA;
      wb_write = 1; wb_rd = 5'd5; wb_data = 32'h1234;
      step();
      chk("byp_a", out_a, BYP ? 32'h1234 : 32'hAAAA);

      idle();
      in_valid = 1; in_rt = 5'd7; rf_data1 = 32'h77; in_rd = 5'd9;
      step();
      in_valid = 1; in_rt = 5'd2; out_ready = 0;
      wb_write = 1; wb_rd = 5'd7; wb_data = 32'hBEEF;
      #1 chk("stall_ready", in_ready, 1'b0);
      step();
      chk("stall_b", out_b, BYP ? 32'hBEEF : 32'h77);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_rd", out_rd, 5'd9);
      hold_b = out_b;
      wb_rd = 5'd0; wb_data = 32'h9999;
      step();
      chk("wb_r0_b", out_b, hold_b);

      idle();
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1; in_rd = 5'(i); in_rs = 5'(i);
         rf_data0 = 32'(i * 16);
         step();
         chk("b2b_rd", out_rd, 5'(i));
         chk("b2b_a", out_a, 32'(i * 16));
      end
      flush = 1; in_valid = 1; in_rd = 5'd20;
      step();
      chk("flush_valid", out_valid, 1'b0);
      idle();
      step();
      chk("flush_nocap", out_valid, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 99) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 19) == 0);
         in_rs     = 5'($urandom_range(0, 7));
         in_rt     = 5'($urandom_range(0, 7));
         in_rd     = 5'($urandom);
         in_imm    = 16'($urandom);
         in_zext   = 1'($urandom);
         in_ctrl   = CW'($urandom);
         rf_data0  = $urandom;
         rf_data1  = $urandom;
         wb_write  = 1'($urandom);
         wb_rd     = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  DATA_W, 32, operand/data width
  CTRL_W, 8, opaque control bundle width
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  clk  input  1  single clock, all state on rising edge
  reset  input  1  synchronous, active-low reset
  in_valid  input  1  decoded instruction offered
  in_ready  output  1  stage can accept this cycle
  in_rs  input  5  source register A index
  in_rt  input  5  source register B index
  in_rd  input  5  destination register index
  in_imm  input  16  raw immediate
  in_zext  input  1  1 = zero-extend imm, 0 = sign-extend
  in_ctrl  input  CTRL_W  control bundle, passed through
  rf_rs  output  5  register-file read address A (= in_rs, combinational)
  rf_rt  output  5  register-file read address B (= in_rt, combinational)
  rf_data0  input  DATA_W  register-file read data A
  rf_data1  input  DATA_W  register-file read data B
  wb_write  input  1  writeback strobe (same strobe drives register-file write)
  wb_rd  input  5  writeback destination
  wb_data  input  DATA_W  writeback data
  flush  input  1  discard held and incoming instruction
  out_valid  output  1  held instruction valid
  out_ready  input  1  downstream accepts
  out_a, out_b  output  DATA_W  resolved operands
  out_imm  output  DATA_W  extended immediate
  out_rs, out_rt, out_rd  output  5  register indices of held instruction
  out_ctrl  output  CTRL_W  held control bundle

Function
REQ-003 SHALL be a one-entry pipeline register with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-004 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-005 SHALL capture all in_* fields and resolved operands on the edge where in_valid && in_ready && flush=0; latency 1 cycle.
REQ-006 EMPTY->FULL on capture; FULL->EMPTY when out_ready && no capture; FULL->FULL when capture coincides with drain.
REQ-007 SHALL resolve operand A as 0 when in_rs==0, else as bypass value (REQ-013) if applicable, else rf_data0; operand B likewise from in_rt/rf_data1.
REQ-008 SHALL form out_imm = {16 zeros, imm} when in_zext=1, else {16 copies of imm[15], imm}.
REQ-009 While FULL and not draining, a wb_write with nonzero wb_rd equal to out_rs SHALL overwrite out_a with wb_data on that edge; same for out_rt/out_b; both may update in one cycle.
REQ-010 Outputs SHALL hold stable while out_valid && !out_ready, except as REQ-009 allows.
REQ-011 flush SHALL force out_valid=0 on the next edge and discard any same-cycle offer; flush has priority over capture and drain.
REQ-012 wb_write with wb_rd==0 SHALL never alter any operand.

Reset
REQ-013-R reset=0 at an edge SHALL set out_valid=0 and out_a, out_b, out_imm, out_rs, out_rt, out_rd, out_ctrl to 0, overriding capture, flush and writeback update; asserted mid-transaction the held instruction is lost.

Configuration
REQ-013 Macro ID_EX_BYPASS_EN defined: on capture, if wb_write && wb_rd!=0 && wb_rd==in_rs, operand A SHALL take wb_data instead of rf_data0 (same for in_rt/B); REQ-009 update active.
REQ-014 ID_EX_BYPASS_EN undefined: operands SHALL come only from rf_data0/rf_data1 (with REQ-007 zero rule), REQ-009 update absent; same-cycle write/read hazards left to the pipeline's hazard unit.

Verification
REQ-015 Reset: hold reset=0 two cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=1.
REQ-016 Capture: in_rs=3, rf_data0=0x11, in_rt=0, rf_data1=0x55, in_imm=0x8001, in_zext=0 -> next cycle out_a=0x11, out_b=0, out_imm=0xFFFF8001.
REQ-017 Bypass (macro on): in_rs=5, rf_data0=0xAAAA, wb_write=1, wb_rd=5, wb_data=0x1234 -> out_a=0x1234; macro off -> out_a=0xAAAA.
REQ-018 Stall update (macro on): FULL with out_rt=7, out_ready=0, wb_write to r7 with 0xBEEF -> out_b=0xBEEF, out_valid stays 1, in_ready=0; wb_rd=0 -> no change.
REQ-019 Back-to-back plus flush: 3 instructions with out_ready=1 -> one per cycle, in order; flush with in_valid=1 -> out_valid=0 next cycle, offered instruction not captured.
